// File: rtl/map_pkg.sv
// Shared types and sizes for the tile map. Used by the SPI decoder, the update controller
// and the address mapper.
package map_pkg;

  localparam int unsigned N_TILES_X = 16;
  localparam int unsigned N_TILES_Y = 8;
  localparam int unsigned N_TILES   = 128;
  localparam int unsigned TILE_BITS = 2;
  localparam int unsigned MAP_BITS  = N_TILES * TILE_BITS;
  localparam int unsigned IDX_BITS  = 7;
  localparam int unsigned Y_BITS    = 10;
  localparam int unsigned CNT_BITS  = 8;

  typedef logic [TILE_BITS-1:0] tile_t;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_FILL   = 2'b01,
    OP_COMMIT = 2'b10,
    OP_NOP    = 2'b11
  } map_op_t;

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_WAIT_VBL = 1'b1
  } map_state_t;

endpackage

// File: rtl/map_update_ctrl_if.sv
// Command channel from the SPI decoder into the map update controller.
interface map_update_ctrl_if;
  import map_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  map_op_t             cmd_op;
  logic [IDX_BITS-1:0] cmd_tile;
  tile_t               cmd_type;

  modport master (
    output cmd_valid, cmd_op, cmd_tile, cmd_type,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_tile, cmd_type,
    output cmd_ready
  );

endinterface

// File: rtl/map_update_ctrl_vblank_detect.sv
// Single-cycle pulse on the first cycle y_cnt reaches the commit line; holding the line
// for the whole scanline produces only one pulse.
module vblank_detect
  import map_pkg::*;
#(
  parameter int unsigned COMMIT_LINE = 503
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [Y_BITS-1:0] y_cnt,
  output logic              vbl
);

  localparam logic [Y_BITS-1:0] LINE = Y_BITS'(COMMIT_LINE);

  logic [Y_BITS-1:0] y_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      y_prev <= '0;
    end else begin
      y_prev <= y_cnt;
    end
  end

  assign vbl = (y_cnt == LINE) && (y_prev != LINE);

endmodule

// File: rtl/map_update_ctrl.sv
// Double-buffered tile map: commands edit a shadow copy, which is copied into the displayed
// map on the first vertical-blank event after a COMMIT.
module map_update_ctrl
  import map_pkg::*;
#(
  parameter int unsigned V_BLANK    = 23,
  parameter int unsigned V_ACTIVE   = 480,
  parameter tile_t       RESET_TYPE = 2'd0
) (
  input  logic                clk,
  input  logic                reset,
  map_update_ctrl_if.slave    cmd,
  input  logic [Y_BITS-1:0]   y_cnt,
  output logic [MAP_BITS-1:0] map,
  output logic                dirty,
  output logic                commit_done,
  output logic [CNT_BITS-1:0] commit_count
);

  localparam int unsigned COMMIT_LINE = V_BLANK + V_ACTIVE;

  map_state_t          state;
  logic [MAP_BITS-1:0] shadow;
  logic                vbl;
  logic                fire;
  logic [7:0]          bit_idx;

  vblank_detect #(
    .COMMIT_LINE (COMMIT_LINE)
  ) u_vblank_detect (
    .clk   (clk),
    .reset (reset),
    .y_cnt (y_cnt),
    .vbl   (vbl)
  );

  // Ready straight from state so the decoder sees back-pressure while a commit is pending.
  assign cmd.cmd_ready = (state == S_IDLE);
  assign fire          = cmd.cmd_valid && cmd.cmd_ready;
  assign bit_idx       = {cmd.cmd_tile, 1'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      shadow       <= {N_TILES{RESET_TYPE}};
      map          <= {N_TILES{RESET_TYPE}};
      dirty        <= 1'b0;
      commit_done  <= 1'b0;
      commit_count <= '0;
    end else begin
      commit_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fire) begin
            case (cmd.cmd_op)
              OP_WRITE: begin
                shadow[bit_idx +: TILE_BITS] <= cmd.cmd_type;
                dirty                        <= 1'b1;
              end
              OP_FILL: begin
                shadow <= {N_TILES{cmd.cmd_type}};
                dirty  <= 1'b1;
              end
              OP_COMMIT: state <= S_WAIT_VBL;
              OP_NOP:    ;
              default:   ;
            endcase
          end
        end
        S_WAIT_VBL: begin
          if (vbl) begin
            map          <= shadow;
            dirty        <= 1'b0;
            commit_done  <= 1'b1;
            commit_count <= commit_count + CNT_BITS'(1);
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_map_update_ctrl.sv
// Directed bench for map_update_ctrl; commit results are checked by a scoreboard monitor.
module tb_map_update_ctrl;
  import map_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic [Y_BITS-1:0]   y_cnt;
  logic [MAP_BITS-1:0] map;
  logic                dirty;
  logic                commit_done;
  logic [CNT_BITS-1:0] commit_count;

  map_update_ctrl_if cmd_bus ();

  map_update_ctrl #(
    .V_BLANK    (23),
    .V_ACTIVE   (480),
    .RESET_TYPE (2'd0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd          (cmd_bus),
    .y_cnt        (y_cnt),
    .map          (map),
    .dirty        (dirty),
    .commit_done  (commit_done),
    .commit_count (commit_count)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int pulse_cnt = 0;

  logic [MAP_BITS-1:0] exp_shadow;
  logic [MAP_BITS-1:0] exp_map;
  logic [CNT_BITS-1:0] exp_count;
  logic                exp_dirty;
  logic [MAP_BITS-1:0] q_map[$];
  logic [CNT_BITS-1:0] q_cnt[$];

  task automatic check(input string name, input logic [MAP_BITS-1:0] act,
                       input logic [MAP_BITS-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: every commit pulse must match the oldest expected commit.
  always @(negedge clk) begin
    if (!reset && commit_done) begin
      pulse_cnt++;
      if (q_map.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_commit: got pulse, expected none at %0t", $time);
      end else begin
        check("commit_map", map, q_map.pop_front());
        check("commit_count", MAP_BITS'(commit_count), MAP_BITS'(q_cnt.pop_front()));
        check("commit_dirty", MAP_BITS'(dirty), '0);
      end
    end
  end

  task automatic set_y(input int v);
    @(posedge clk);
    #1 y_cnt = Y_BITS'(v);
  endtask

  task automatic model_reset();
    exp_shadow = '0;
    exp_map    = '0;
    exp_count  = '0;
    exp_dirty  = 1'b0;
  endtask

  task automatic expect_commit();
    exp_count = exp_count + 8'd1;
    exp_map   = exp_shadow;
    exp_dirty = 1'b0;
    q_map.push_back(exp_map);
    q_cnt.push_back(exp_count);
  endtask

  task automatic send(input map_op_t op, input int tile, input logic [1:0] typ);
    bit ok = 0;
    @(posedge clk);
    #1;
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_op    = op;
    cmd_bus.cmd_tile  = IDX_BITS'(tile);
    cmd_bus.cmd_type  = typ;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (cmd_bus.cmd_ready) begin
        @(posedge clk);
        #1;
        ok = 1;
        break;
      end
    end
    cmd_bus.cmd_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL handshake_timeout: got no ready, expected ready at %0t", $time);
    end
    case (op)
      OP_WRITE: begin exp_shadow[2*tile +: 2] = typ; exp_dirty = 1'b1; end
      OP_FILL:  begin exp_shadow = {N_TILES{typ}}; exp_dirty = 1'b1; end
      default:  ;
    endcase
  endtask

  task automatic frame_vbl(input int hold);
    set_y(502);
    set_y(503);
    repeat (hold) @(posedge clk);
    set_y(0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MAP_BITS-1:0] fill_exp;
    int p0;

    reset = 1'b1;
    y_cnt = '0;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_op    = OP_NOP;
    cmd_bus.cmd_tile  = '0;
    cmd_bus.cmd_type  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_map", map, '0);
    check("reset_dirty", MAP_BITS'(dirty), '0);
    check("reset_ready", MAP_BITS'(cmd_bus.cmd_ready), MAP_BITS'(1));
    check("reset_count", MAP_BITS'(commit_count), '0);

    // WRITE tile 17 = 3, commit on 502->503 with exact pulse timing
    send(OP_WRITE, 17, 2'b11);
    @(negedge clk);
    check("write_dirty", MAP_BITS'(dirty), MAP_BITS'(1));
    check("write_map_hold", map, '0);
    set_y(502);
    send(OP_COMMIT, 0, 2'b00);
    @(negedge clk);
    check("wait_ready", MAP_BITS'(cmd_bus.cmd_ready), '0);
    expect_commit();
    set_y(503);
    @(negedge clk);
    check("pulse_early", MAP_BITS'(commit_done), '0);
    @(negedge clk);
    check("pulse_on", MAP_BITS'(commit_done), MAP_BITS'(1));
    check("tile17", MAP_BITS'(map[35:34]), MAP_BITS'(2'b11));
    @(negedge clk);
    check("pulse_off", MAP_BITS'(commit_done), '0);
    check("commit1_count", MAP_BITS'(commit_count), MAP_BITS'(1));
    check("commit1_ready", MAP_BITS'(cmd_bus.cmd_ready), MAP_BITS'(1));
    set_y(0);

    // WRITE without COMMIT: two frames, map unchanged
    send(OP_WRITE, 5, 2'b01);
    frame_vbl(10);
    frame_vbl(10);
    @(negedge clk);
    check("nocommit_map", map, exp_map);
    check("nocommit_dirty", MAP_BITS'(dirty), MAP_BITS'(1));

    // COMMIT, held valid during WAIT_VBL, y held at 503 for 800 cycles
    set_y(502);
    send(OP_COMMIT, 0, 2'b00);
    expect_commit();
    @(posedge clk);
    #1;
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_op    = OP_COMMIT;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("held_ready", MAP_BITS'(cmd_bus.cmd_ready), '0);
    end
    p0 = pulse_cnt;
    set_y(503);
    @(posedge clk);
    @(posedge clk);
    #1 cmd_bus.cmd_valid = 1'b0;
    repeat (798) @(posedge clk);
    @(negedge clk);
    check("hold_pulses", MAP_BITS'(pulse_cnt - p0), MAP_BITS'(1));
    check("second_wait_ready", MAP_BITS'(cmd_bus.cmd_ready), '0);
    check("hold_map", map, exp_map);
    expect_commit();
    set_y(0);
    frame_vbl(4);
    @(negedge clk);
    check("second_commit_count", MAP_BITS'(commit_count), MAP_BITS'(3));
    check("second_ready", MAP_BITS'(cmd_bus.cmd_ready), MAP_BITS'(1));

    // FILL 2, WRITE tile 127 = 1
    send(OP_FILL, 0, 2'b10);
    send(OP_NOP, 3, 2'b11);
    send(OP_WRITE, 127, 2'b01);
    send(OP_COMMIT, 0, 2'b00);
    expect_commit();
    frame_vbl(4);
    @(negedge clk);
    fill_exp = {2'b01, {127{2'b10}}};
    check("fill_map", map, fill_exp);

    // Reset while waiting abandons the commit
    set_y(502);
    send(OP_COMMIT, 0, 2'b00);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    frame_vbl(4);
    @(negedge clk);
    check("abort_ready", MAP_BITS'(cmd_bus.cmd_ready), MAP_BITS'(1));
    check("abort_map", map, '0);
    check("abort_count", MAP_BITS'(commit_count), '0);
    check("abort_dirty", MAP_BITS'(dirty), '0);

    // 256 commits wrap the counter back to 0
    for (int i = 0; i < 256; i++) begin
      if (i == 100) send(OP_WRITE, 64, 2'b10);
      send(OP_COMMIT, 0, 2'b00);
      expect_commit();
      frame_vbl(2);
    end
    @(negedge clk);
    check("wrap_count", MAP_BITS'(commit_count), '0);
    check("wrap_map", map, exp_map);
    check("queue_empty", MAP_BITS'(q_map.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
